cbd_sampler: RTL and testbench

// - Centered-binomial (CBD_eta) sampler for ML-KEM KeyGen/Encaps, directly downstream of the PRNG256 stage.
// - Consumes 256-bit PRNG words over a valid/ready handshake.
// - Emits the 256 coefficients of one polynomial in [0,Q), LANES coefficients per beat, to the NTT/poly store.
// - Started by the KeyGen FSM sampler-enable rising edge; reports completion with a done pulse.

---
 rtl/cbd_sampler.sv | 110 +++++++++++
 tb/tb_cbd_sampler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbd_sampler.sv
// Centered-binomial (CBD_eta) sampler: turns 2*ETA PRNG words into 256 coefficients in [0,Q),
// LANES coefficients per output beat, through a 512-bit shift buffer.
module cbd_sampler #(
    parameter int ETA   = 2,
    parameter int LANES = 4,
    parameter int Q     = 3329
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic [255:0]          din_i,
    input  logic                  din_vld_i,
    output logic                  din_rdy_o,
    output logic [LANES*12-1:0]   coef_o,
    output logic [7:0]            coef_idx_o,
    output logic                  coef_vld_o,
    input  logic                  coef_rdy_i
);

    localparam int B     = LANES * 2 * ETA;
    localparam int WORDS = 2 * ETA;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic [511:0] sbuf, sbuf_nxt;
    logic [9:0]   fill, fill_nxt;
    logic [2:0]   words_in;
    logic [7:0]   idx;
    logic         take_word, take_beat, last_beat;
    logic [2:0]   pa, pb;

    assign din_rdy_o  = (state == RUN) && (words_in < 3'(WORDS)) && (fill <= 10'd256);
    assign coef_vld_o = (state == RUN) && (fill >= 10'(B));
    assign take_word  = din_vld_i && din_rdy_o;
    assign take_beat  = coef_vld_o && coef_rdy_i;
    assign last_beat  = take_beat && (idx == 8'(256 - LANES));
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);
    assign coef_idx_o = idx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift out the accepted beat first, then land the new word just above the remaining bits.
    always_comb begin
        sbuf_nxt = sbuf;
        fill_nxt = fill;
        if (take_beat) begin
            sbuf_nxt = sbuf >> B;
            fill_nxt = fill - 10'(B);
        end
        if (take_word) begin
            sbuf_nxt = sbuf_nxt | ({256'b0, din_i} << fill_nxt);
            fill_nxt = fill_nxt + 10'd256;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sbuf     <= '0;
            fill     <= '0;
            words_in <= '0;
            idx      <= '0;
        end else if (state != RUN) begin
            sbuf     <= '0;
            fill     <= '0;
            words_in <= '0;
            idx      <= '0;
        end else begin
            sbuf <= sbuf_nxt;
            fill <= fill_nxt;
            if (take_word) words_in <= words_in + 3'd1;
            if (take_beat) idx <= idx + 8'(LANES);
        end
    end

    always_comb begin
        coef_o = '0;
        pa     = '0;
        pb     = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            pa = '0;
            pb = '0;
            for (int unsigned i = 0; i < ETA; i++) begin
                pa = pa + 3'(sbuf[2*ETA*j + i]);
                pb = pb + 3'(sbuf[2*ETA*j + ETA + i]);
            end
            coef_o[12*j +: 12] = (pa >= pb) ? 12'(pa - pb) : 12'(Q) - 12'(pb - pa);
        end
    end

endmodule

// File: tb/tb_cbd_sampler.sv
// Scoreboard bench: dut0 runs ETA=2/LANES=4, dut1 runs ETA=3/LANES=2 (word-straddling coefficients).
module tb_cbd_sampler;

    localparam int Q = 3329;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start [2];
    logic         busy  [2];
    logic         done  [2];
    logic [255:0] din   [2];
    logic         dvld  [2];
    logic         drdy  [2];
    logic [7:0]   cidx  [2];
    logic         cvld  [2];
    logic         crdy  [2];
    logic [47:0]  coef0;
    logic [23:0]  coef1;

    always #5 clk = ~clk;

    cbd_sampler #(.ETA(2), .LANES(4), .Q(Q)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
        .din_i(din[0]), .din_vld_i(dvld[0]), .din_rdy_o(drdy[0]), .coef_o(coef0),
        .coef_idx_o(cidx[0]), .coef_vld_o(cvld[0]), .coef_rdy_i(crdy[0]));

    cbd_sampler #(.ETA(3), .LANES(2), .Q(Q)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
        .din_i(din[1]), .din_vld_i(dvld[1]), .din_rdy_o(drdy[1]), .coef_o(coef1),
        .coef_idx_o(cidx[1]), .coef_vld_o(cvld[1]), .coef_rdy_i(crdy[1]));

    int total = 0;
    int bad = 0;
    int gap = 0;
    int rgap = 0;
    logic stall [2];
    logic acc [2];
    logic held [2];
    longint hc [2];
    int hi [2];
    int nidx [2];
    int wtot [2];
    int ctot [2];
    int wb [2];
    int cb [2];
    int done_cnt [2];
    int dexp [2];

    logic [255:0] wq0 [$];
    logic [255:0] wq1 [$];
    int exp0 [$];
    int exp1 [$];

    function automatic int eta(input int k);
        return k != 0 ? 3 : 2;
    endfunction
    function automatic int lanes(input int k);
        return k != 0 ? 2 : 4;
    endfunction
    function automatic int wq_size(input int k);
        return k != 0 ? wq1.size() : wq0.size();
    endfunction
    function automatic logic [255:0] wq_front(input int k);
        return k != 0 ? wq1[0] : wq0[0];
    endfunction
    function automatic void wq_pop(input int k);
        if (k != 0) void'(wq1.pop_front()); else void'(wq0.pop_front());
    endfunction
    function automatic void wq_push(input int k, input logic [255:0] v);
        if (k != 0) wq1.push_back(v); else wq0.push_back(v);
    endfunction
    function automatic void wq_clear(input int k);
        if (k != 0) wq1.delete(); else wq0.delete();
    endfunction
    function automatic int exp_size(input int k);
        return k != 0 ? exp1.size() : exp0.size();
    endfunction
    function automatic int exp_pop(input int k);
        return k != 0 ? exp1.pop_front() : exp0.pop_front();
    endfunction
    function automatic void exp_push(input int k, input int v);
        if (k != 0) exp1.push_back(v); else exp0.push_back(v);
    endfunction
    function automatic void exp_clear(input int k);
        if (k != 0) exp1.delete(); else exp0.delete();
    endfunction
    function automatic longint lane_coef(input int k, input int l);
        return k != 0 ? longint'(coef1[12*l +: 12]) : longint'(coef0[12*l +: 12]);
    endfunction
    function automatic longint coef_all(input int k);
        return k != 0 ? longint'(coef1) : longint'(coef0);
    endfunction

    task automatic chk(input string name, input int k, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, want, $time);
        end
    endtask

    // Reference: coefficient j = popcount(stream[2e*j +: e]) - popcount(stream[2e*j+e +: e]) mod Q.
    task automatic issue_poly(input int k, input logic [255:0] w [6]);
        int e;
        e = eta(k);
        for (int i = 0; i < 2 * e; i++) wq_push(k, w[i]);
        for (int j = 0; j < 256; j++) begin
            int a, b, p;
            a = 0;
            b = 0;
            for (int i = 0; i < e; i++) begin
                p = 2 * e * j + i;
                a += int'(w[p / 256][p % 256]);
                p = p + e;
                b += int'(w[p / 256][p % 256]);
            end
            exp_push(k, (a - b + Q) % Q);
        end
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] v;
        for (int m = 0; m < 8; m++) v[32*m +: 32] = $urandom;
        return v;
    endfunction

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk);
        start[0] = m[0];
        start[1] = m[1];
        @(negedge clk);
        start[0] = 1'b0;
        start[1] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int t;
        t = 0;
        while (done_cnt[k] == dexp[k] && t < budget) begin
            @(negedge clk);
            #3;
            t++;
        end
        dexp[k]++;
        chk("done_timeout", k, longint'(t < budget), 1);
        @(negedge clk);
        #3;
        chk("busy_after_done", k, longint'(busy[k]), 0);
        chk("done_width", k, longint'(done[k]), 0);
        chk("done_count", k, done_cnt[k], dexp[k]);
        chk("coef_count", k, ctot[k] - cb[k], 256);
        chk("words_left", k, wq_size(k), 0);
    endtask

    // Driver: inputs change on the falling edge; handshakes are judged 1 ns later.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                wq_clear(k);
                acc[k] = 1'b0;
            end else if (acc[k]) begin
                wq_pop(k);
                wtot[k]++;
                acc[k] = 1'b0;
            end
            dvld[k] = rst_n && (wq_size(k) > 0) && (int'($urandom_range(99)) >= gap);
            din[k]  = dvld[k] ? wq_front(k) : '0;
            crdy[k] = !stall[k] && (int'($urandom_range(99)) >= rgap);
        end
        #1;
        for (int k = 0; k < 2; k++) acc[k] = rst_n && dvld[k] && drdy[k];
    end

    // Monitor: checks handshake rules against a bit-count model and pops the scoreboard per beat.
    always @(negedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk("reset_outputs", k, {busy[k], done[k], drdy[k], cvld[k], cidx[k], coef_all(k)}, 0);
                held[k] = 1'b0;
                nidx[k] = 0;
            end else begin
                int fillm, wused;
                logic run;
                if (start[k] && !busy[k]) begin
                    wb[k] = wtot[k];
                    cb[k] = ctot[k];
                    nidx[k] = 0;
                end
                run   = busy[k] && !done[k];
                wused = wtot[k] - wb[k];
                fillm = 256 * wused - 2 * eta(k) * (ctot[k] - cb[k]);
                chk("din_rdy_rule", k, longint'(drdy[k]),
                    longint'(run && wused < 2 * eta(k) && fillm <= 256));
                chk("coef_vld_rule", k, longint'(cvld[k]),
                    longint'(run && fillm >= 2 * eta(k) * lanes(k)));
                if (cvld[k]) begin
                    if (held[k]) begin
                        chk("stall_coef_stable", k, coef_all(k), hc[k]);
                        chk("stall_idx_stable", k, longint'(cidx[k]), hi[k]);
                    end
                    if (crdy[k]) begin
                        chk("coef_idx", k, longint'(cidx[k]), nidx[k]);
                        for (int l = 0; l < lanes(k); l++) begin
                            if (exp_size(k) == 0) chk("unexpected_coef", k, lane_coef(k, l), -1);
                            else chk("coef_value", k, lane_coef(k, l), exp_pop(k));
                        end
                        ctot[k] += lanes(k);
                        nidx[k] = (nidx[k] + lanes(k)) % 256;
                        held[k] = 1'b0;
                    end else begin
                        held[k] = 1'b1;
                        hc[k] = coef_all(k);
                        hi[k] = int'(cidx[k]);
                    end
                end else begin
                    held[k] = 1'b0;
                end
                if (done[k]) begin
                    done_cnt[k]++;
                    chk("done_scoreboard_empty", k, exp_size(k), 0);
                    chk("words_consumed", k, wused, 2 * eta(k));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] w [6];
        logic [255:0] w1 [6];
        int t, dc;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; stall[k] = 1'b0; acc[k] = 1'b0; held[k] = 1'b0;
            hc[k] = 0; hi[k] = 0; nidx[k] = 0; wtot[k] = 0; ctot[k] = 0;
            wb[k] = 0; cb[k] = 0; done_cnt[k] = 0; dexp[k] = 0;
        end
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;

        // All-zero words, no stalls: 64 zero beats.
        for (int i = 0; i < 6; i++) w[i] = '0;
        issue_poly(0, w);
        pulse_start(2'b01);
        wait_done(0, 400);

        for (int i = 0; i < 6; i++) w[i] = {64{4'h3}};
        issue_poly(0, w);
        pulse_start(2'b01);
        wait_done(0, 400);
        for (int i = 0; i < 6; i++) w[i] = {64{4'hC}};
        issue_poly(0, w);
        pulse_start(2'b01);
        wait_done(0, 400);

        // ETA=3: coefficient 42 spans word0 bits 252..255 and word1 bits 0..1.
        for (int i = 0; i < 6; i++) w[i] = '0;
        w[0][255:252] = 4'hF;
        w[1][1:0] = 2'b00;
        issue_poly(1, w);
        pulse_start(2'b10);
        wait_done(1, 600);

        // Consumer stall for 20 cycles mid-run.
        for (int i = 0; i < 6; i++) w[i] = rand_word();
        issue_poly(0, w);
        pulse_start(2'b01);
        repeat (12) @(negedge clk);
        stall[0] = 1'b1;
        repeat (20) @(negedge clk);
        #3 chk("din_rdy_low_when_full", 0, longint'(drdy[0]), 0);
        stall[0] = 1'b0;
        wait_done(0, 600);

        // Reset mid-polynomial at index 128, then a fresh polynomial.
        gap = 20;
        rgap = 20;
        for (int i = 0; i < 6; i++) w[i] = rand_word();
        issue_poly(0, w);
        pulse_start(2'b01);
        t = 0;
        while (!(cvld[0] && cidx[0] == 8'd128) && t < 2000) begin
            @(negedge clk);
            #3;
            t++;
        end
        chk("reach_idx_128", 0, longint'(t < 2000), 1);
        dc = done_cnt[0];
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_clear(0);
        exp_clear(1);
        #3 rst_n = 1'b1;
        chk("no_done_across_reset", 0, done_cnt[0], dc);
        for (int i = 0; i < 6; i++) w[i] = rand_word();
        issue_poly(0, w);
        pulse_start(2'b01);
        wait_done(0, 2000);

        // Random gaps/stalls on both instances with a second start during RUN.
        gap = 40;
        rgap = 30;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 6; i++) begin
                w[i] = rand_word();
                w1[i] = rand_word();
            end
            issue_poly(0, w);
            issue_poly(1, w1);
            pulse_start(2'b11);
            repeat (25) @(negedge clk);
            pulse_start(2'b11);
            wait_done(0, 3000);
            wait_done(1, 3000);
        end

        repeat (10) @(negedge clk);
        #3;
        chk("final_done_count", 0, done_cnt[0], dexp[0]);
        chk("final_done_count", 1, done_cnt[1], dexp[1]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
